dvfs_governor: RTL

Utilization-driven requester for the PMU DVFS path. The block measures per-domain activity (CPU/NPU/GPU) over fixed windows and converts the result to a DVFS profile. It drives `dvfs_request` into the DVFS controller and tracks the controller's `busy` handshake so that only one change is in flight at a time. Thermal throttle and software force inputs override the automatic policy.

---
 rtl/dvfs_pkg.sv | 26 ++
 rtl/dvfs_activity_counter.sv | 71 +++++++
 rtl/dvfs_governor.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dvfs_pkg.sv
// Shared profile encodings, request type and governor FSM states for the DVFS requester.
package dvfs_pkg;

    localparam int unsigned REQ_W = 4;

    typedef logic [REQ_W-1:0] dvfs_req_t;

    localparam dvfs_req_t PROF_LOW  = 4'd0;
    localparam dvfs_req_t PROF_SAVE = 4'd1;
    localparam dvfs_req_t PROF_BAL  = 4'd2;
    localparam dvfs_req_t PROF_PERF = 4'd3;
    localparam dvfs_req_t PROF_HIGH = 4'd4;
    localparam dvfs_req_t PROF_MAX  = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE
    } gov_state_t;

    // Any out-of-range software value maps to the top profile.
    function automatic dvfs_req_t clamp_profile(input dvfs_req_t p);
        return (p > PROF_MAX) ? PROF_MAX : p;
    endfunction

endpackage

// File: rtl/dvfs_activity_counter.sv
// Per-domain activity counting over fixed 2^WINDOW_LOG2 windows; reports the
// busiest domain's utilization % together with a window-end strobe.
module dvfs_activity_counter #(
    parameter int unsigned WINDOW_LOG2 = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       cpu_active,
    input  logic       npu_active,
    input  logic       gpu_active,
    output logic       win_end_c,
    output logic [7:0] pct_c
);

    localparam int unsigned CNT_W  = WINDOW_LOG2 + 1;
    localparam int unsigned PROD_W = WINDOW_LOG2 + 8;
    localparam int unsigned N_DOM  = 3;

    logic [WINDOW_LOG2-1:0]       win_cnt;
    logic [N_DOM-1:0][CNT_W-1:0]  dom_cnt;
    logic [N_DOM-1:0][CNT_W-1:0]  dom_next;
    logic [N_DOM-1:0]             act;
    logic [CNT_W-1:0]             max_cnt;
    logic [PROD_W-1:0]            prod;
    logic [7:0]                   pct_raw;

    assign act       = {gpu_active, npu_active, cpu_active};
    assign win_end_c = en && (win_cnt == '1);

    // Counts including this cycle's activity, so window end sees the final cycle.
    always_comb begin
        for (int i = 0; i < int'(N_DOM); i++) begin
            dom_next[i] = dom_cnt[i];
            if (act[i] && (dom_cnt[i] != '1)) begin
                dom_next[i] = dom_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        max_cnt = dom_next[0];
        if (dom_next[1] > max_cnt) begin
            max_cnt = dom_next[1];
        end
        if (dom_next[2] > max_cnt) begin
            max_cnt = dom_next[2];
        end
        prod    = PROD_W'(max_cnt) * PROD_W'(100);
        pct_raw = 8'(prod >> WINDOW_LOG2);
        pct_c   = (pct_raw > 8'd100) ? 8'd100 : pct_raw;
    end

    // Counters are held cleared while disabled and restart at each window end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt <= '0;
            dom_cnt <= '0;
        end else if (!en) begin
            win_cnt <= '0;
            dom_cnt <= '0;
        end else if (win_cnt == '1) begin
            win_cnt <= '0;
            dom_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WINDOW_LOG2'(1);
            dom_cnt <= dom_next;
        end
    end

endmodule

// File: rtl/dvfs_governor.sv
// Utilization-driven DVFS profile requester: streak hysteresis, thermal/force
// override priority and a single-outstanding busy handshake with ack timeout.
module dvfs_governor
    import dvfs_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2  = 10,
    parameter int unsigned UP_THRESH    = 80,
    parameter int unsigned DOWN_THRESH  = 30,
    parameter int unsigned HOLD_WINDOWS = 2,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       cpu_active,
    input  logic       npu_active,
    input  logic       gpu_active,
    input  logic       thermal_throttle,
    input  logic       force_valid,
    input  logic [3:0] force_profile,
    input  logic       dvfs_busy,
    output logic [3:0] dvfs_request,
    output logic       req_pending,
    output logic [7:0] util_pct,
    output logic       ack_timeout
);

    localparam int unsigned STREAK_W = $clog2(HOLD_WINDOWS + 1);
    localparam int unsigned TIMER_W  = $clog2(ACK_TIMEOUT + 1);

    gov_state_t          state_q, state_d;
    dvfs_req_t           req_q, req_d;
    logic [STREAK_W-1:0] up_q, up_d, dn_q, dn_d;
    logic                fpend_q, fpend_d;
    dvfs_req_t           fval_q, fval_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [7:0]          util_q, util_d;
    logic                ack_q, ack_d;
    logic                pending_q;

    logic                win_end_c;
    logic [7:0]          pct_c;
    logic                issue;
    dvfs_req_t           target;
    dvfs_req_t           force_tgt;

    dvfs_activity_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_activity (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .cpu_active (cpu_active),
        .npu_active (npu_active),
        .gpu_active (gpu_active),
        .win_end_c  (win_end_c),
        .pct_c      (pct_c)
    );

    assign dvfs_request = req_q;
    assign req_pending  = pending_q;
    assign util_pct     = util_q;
    assign ack_timeout  = ack_q;

    // Next-state, streak, force latch and issue decision.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        up_d      = up_q;
        dn_d      = dn_q;
        fpend_d   = fpend_q;
        fval_d    = fval_q;
        timer_d   = timer_q;
        util_d    = util_q;
        ack_d     = 1'b0;
        issue     = 1'b0;
        target    = req_q;
        force_tgt = PROF_LOW;

        if (!en) begin
            up_d = '0;
            dn_d = '0;
        end else if (win_end_c) begin
            util_d = pct_c;
            if (pct_c >= 8'(UP_THRESH)) begin
                dn_d = '0;
                up_d = (up_q == STREAK_W'(HOLD_WINDOWS)) ? up_q : up_q + STREAK_W'(1);
            end else if (pct_c <= 8'(DOWN_THRESH)) begin
                up_d = '0;
                dn_d = (dn_q == STREAK_W'(HOLD_WINDOWS)) ? dn_q : dn_q + STREAK_W'(1);
            end else begin
                up_d = '0;
                dn_d = '0;
            end
        end

        // One-deep force slot; a newer pulse replaces an unserved one.
        if (force_valid) begin
            fpend_d = 1'b1;
            fval_d  = force_profile;
        end
        force_tgt = clamp_profile(fval_d);
        if (thermal_throttle && (force_tgt > PROF_SAVE)) begin
            force_tgt = PROF_SAVE;
        end

        case (state_q)
            IDLE: begin
                if (thermal_throttle && (req_q > PROF_SAVE)) begin
                    issue  = 1'b1;
                    target = PROF_SAVE;
                end else if (fpend_d) begin
                    issue   = 1'b1;
                    target  = force_tgt;
                    fpend_d = 1'b0;
                end else if (win_end_c && !thermal_throttle) begin
                    if (up_d == STREAK_W'(HOLD_WINDOWS)) begin
                        target = (req_q == PROF_MAX) ? req_q : req_q + dvfs_req_t'(1);
                    end else if (dn_d == STREAK_W'(HOLD_WINDOWS)) begin
                        target = (req_q == PROF_LOW) ? req_q : req_q - dvfs_req_t'(1);
                    end
                    issue = (target != req_q);
                end
                if (issue) begin
                    req_d   = target;
                    state_d = WAIT_ACK;
                    timer_d = '0;
                    up_d    = '0;
                    dn_d    = '0;
                end
            end
            WAIT_ACK: begin
                if (timer_q == TIMER_W'(ACK_TIMEOUT)) begin
                    state_d = IDLE;
                end else if (dvfs_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    ack_d   = (timer_q == TIMER_W'(ACK_TIMEOUT - 1));
                end
            end
            WAIT_DONE: begin
                if (!dvfs_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            req_q     <= PROF_BAL;
            up_q      <= '0;
            dn_q      <= '0;
            fpend_q   <= 1'b0;
            fval_q    <= PROF_LOW;
            timer_q   <= '0;
            util_q    <= '0;
            ack_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            fpend_q   <= fpend_d;
            fval_q    <= fval_d;
            timer_q   <= timer_d;
            util_q    <= util_d;
            ack_q     <= ack_d;
            pending_q <= (state_d != IDLE);
        end
    end

endmodule
